load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit sitting between the CPU execute stage and the word-addressed data memory. Accepts one RV32I load or store request at a time over a valid/ready handshake and drives the memory's single word port (address, write_data, write_enable, combinational read_data). Byte/halfword loads are extracted and sign- or zero-extended; byte/halfword stores are performed as read-modify-write. Misaligned, out-of-range and illegal-funct3 requests complete with an error response and no memory write.

## Interface

- WORDS, 64, memory depth in 32-bit words; power of two, ≥2; valid byte addresses are 0 .. 4*WORDS-1
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr  input  32  byte address
- req_wdata  input  32  store data (low byte/halfword used for SB/SH)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  32  load result; 0 for stores and errors
- rsp_err  output  1  request was misaligned, out of range or illegal
- mem_address  output  32  to memory; always word-aligned (bits [1:0] = 0)
- mem_write_data  output  32  to memory
- mem_write_enable  output  1  to memory; one-cycle pulse per store
- mem_read_data  input  32  from memory, combinational on mem_address

## Operation

- States: IDLE, LOAD, STORE_RD, STORE_WR, RESP.
- IDLE: req_ready=1. On req_valid: latch we, funct3, addr, wdata; check, in priority order: illegal funct3 (load 011/110/111; store ≥011), out of range (addr ≥ 4*WORDS), misaligned (word ops addr[1:0]≠0; half ops addr[0]≠0). Any failure -> RESP with rsp_err=1. Else load -> LOAD; SW -> STORE_WR; SB/SH -> STORE_RD.
- LOAD: mem_address = {addr[31:2],2'b00}. Select byte addr[1:0] (bits 8*k+7:8*k) or halfword addr[1] (bits 16*h+15:16*h); LB/LH sign-extend, LBU/LHU zero-extend, LW whole word. Register into rsp_data -> RESP.
- STORE_RD: mem_address aligned; merge req_wdata[7:0] (SB) or [15:0] (SH) into captured mem_read_data at the selected lane, other lanes unchanged; register merged word -> STORE_WR.
- STORE_WR: mem_write_enable=1, mem_write_data = merged word (SW: req_wdata). -> RESP.
- RESP: rsp_valid=1, rsp_data/rsp_err stable; on rsp_ready -> IDLE. No new request accepted in RESP.
- mem_write_enable=1 only in STORE_WR. mem_address holds the latched aligned address outside IDLE; in IDLE it holds its last value.

## Timing

- Request accepted on edge where req_valid & req_ready (cycle 0).
- Load: LOAD in cycle 1; rsp_valid in cycle 2.
- SW: write pulse cycle 1; rsp_valid cycle 2.
- SB/SH: read cycle 1, write pulse cycle 2; rsp_valid cycle 3.
- Error: rsp_valid cycle 1; no mem_write_enable ever asserted.
- rsp_ready high while rsp_valid: return to IDLE next edge; next request accepted at earliest one cycle after the response handshake (req_ready=0 during RESP).
- rsp_ready held low: stay in RESP indefinitely, outputs unchanged.
- Reset values: state IDLE, req_ready=1 on the first cycle after reset, rsp_valid=0, rsp_data=0, rsp_err=0, mem_address=0, mem_write_data=0, mem_write_enable=0.
- rst asserted in any state (including STORE_WR): next state IDLE, mem_write_enable forced 0 in the reset cycle, in-flight request dropped with no response.
- Highest valid address 4*WORDS-1 (byte) accepted; 4*WORDS rejected.

## Test plan

- Word 1 = 0x8765_4321; LB addr 0x7 -> rsp_data 0xFFFF_FF87 at cycle 2; LBU addr 0x7 -> 0x0000_0087; LH addr 0x4 -> 0x0000_4321; LHU addr 0x6 -> 0x0000_8765.
- Word 2 = 0x1122_3344; SB addr 0x9, wdata 0xAABB_CCDD -> one write pulse cycle 2 with 0x1122_DD44; subsequent LW addr 0x8 -> 0x1122_DD44.
- SW addr 0xC, wdata 0xDEAD_BEEF -> write pulse cycle 1, rsp_valid cycle 2, rsp_err=0, rsp_data=0.
- LW addr 0x2, SH addr 0x1, LB addr 0x100 (WORDS=64), load funct3 011 -> each rsp_err=1, rsp_data=0, rsp_valid at cycle 1, mem_write_enable never high.
- Hold rsp_ready=0 for 5 cycles after a load -> rsp_valid/rsp_data stable, req_ready=0, new req_valid ignored; release -> IDLE next edge.
- Assert rst during STORE_RD of an SH -> no write pulse, no response, req_ready=1 next cycle, memory unchanged.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory word port of the load/store unit.
// The slave modport is the unit; the master modport is the CPU and memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_read_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, mem_address, mem_write_data,
    output mem_write_enable
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_read_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mem_address, mem_write_data,
    input  mem_write_enable
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, sub-word loads extracted and extended,
// sub-word stores done as read-modify-write on a word-addressed memory.
module load_store_unit #(
  parameter int unsigned WORDS = 64
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  localparam logic [31:0] AddrLimit = 32'(4 * WORDS);

  typedef enum logic [2:0] {StIdle, StLoad, StStoreRd, StStoreWr, StResp} state_e;

  state_e      state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [15:0] wdata_lo_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_data_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_write_data_q;
  logic        mem_write_enable_q;

  logic        illegal;
  logic        out_of_range;
  logic        misaligned;
  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    if (bus.req_we) illegal = bus.req_funct3 > 3'd2;
    else            illegal = bus.req_funct3 inside {3'b011, 3'b110, 3'b111};
    out_of_range = bus.req_addr >= AddrLimit;
    case (bus.req_funct3[1:0])
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    req_err = illegal | out_of_range | misaligned;
  end

  always_comb begin
    lane_byte = 8'(bus.mem_read_data >> {addr_lo_q, 3'b000});
    lane_half = 16'(bus.mem_read_data >> {addr_lo_q[1], 4'b0000});
    case (funct3_q)
      3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_val = {24'h0, lane_byte};
      3'b101:  load_val = {16'h0, lane_half};
      default: load_val = bus.mem_read_data;
    endcase
    // Only the addressed lane is replaced; the rest comes from the word just read.
    merged = bus.mem_read_data;
    if (funct3_q[0]) merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_lo_q;
    else             merged[{addr_lo_q, 3'b000} +: 8]    = wdata_lo_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= StIdle;
      funct3_q           <= 3'b000;
      addr_lo_q          <= 2'b00;
      wdata_lo_q         <= 16'h0;
      req_ready_q        <= 1'b1;
      rsp_valid_q        <= 1'b0;
      rsp_err_q          <= 1'b0;
      rsp_data_q         <= 32'h0;
      mem_address_q      <= 32'h0;
      mem_write_data_q   <= 32'h0;
      mem_write_enable_q <= 1'b0;
    end else begin
      mem_write_enable_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            req_ready_q   <= 1'b0;
            funct3_q      <= bus.req_funct3;
            addr_lo_q     <= bus.req_addr[1:0];
            wdata_lo_q    <= bus.req_wdata[15:0];
            mem_address_q <= {bus.req_addr[31:2], 2'b00};
            rsp_data_q    <= 32'h0;
            rsp_err_q     <= 1'b0;
            if (req_err) begin
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end else if (!bus.req_we) begin
              state_q <= StLoad;
            end else if (bus.req_funct3 == 3'b010) begin
              mem_write_data_q   <= bus.req_wdata;
              mem_write_enable_q <= 1'b1;
              state_q            <= StStoreWr;
            end else begin
              state_q <= StStoreRd;
            end
          end
        end
        StLoad: begin
          rsp_data_q  <= load_val;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StStoreRd: begin
          mem_write_data_q   <= merged;
          mem_write_enable_q <= 1'b1;
          state_q            <= StStoreWr;
        end
        StStoreWr: begin
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready        = req_ready_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.rsp_err          = rsp_err_q;
  assign bus.mem_address      = mem_address_q;
  assign bus.mem_write_data   = mem_write_data_q;
  // Reset suppresses a pending write pulse within the reset cycle itself.
  assign bus.mem_write_enable = mem_write_enable_q & ~rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, randomized requests against a byte-level
// reference model, plus back-pressure and mid-store reset sequences.
module tb_load_store_unit;
  localparam int unsigned WORDS = 64;
  localparam int AW = $clog2(WORDS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];
  bit          init_mem = 1'b0;
  int          wr_total = 0;

  assign bus.mem_read_data = mem[bus.mem_address[AW+1:2]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < int'(WORDS); i++) mem[i] <= ref_mem[i];
    end else if (bus.mem_write_enable) begin
      mem[bus.mem_address[AW+1:2]] <= bus.mem_write_data;
      wr_total <= wr_total + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] data;
    int          lat;
    int          wcyc;
    logic [31:0] wword;
  } vec_t;

  vec_t vecs[$];

  // Reference: byte-lane arithmetic on the reference memory image.
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output bit err,
                                output logic [31:0] data, output int lat, output int wcyc,
                                output logic [31:0] wword);
    int          bytes;
    int          off;
    bit          illegal;
    logic [63:0] word, mask, val;
    bytes   = 1 << int'(f3 & 3'd3);
    illegal = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err     = illegal || (addr >= 32'(4 * WORDS)) || ((addr % 32'(bytes)) != 0);
    data    = 32'h0;
    lat     = 1;
    wcyc    = -1;
    wword   = 32'h0;
    if (err) return;
    word = 64'(ref_mem[addr / 4]);
    off  = int'(addr % 4);
    mask = (64'd1 << (8 * bytes)) - 64'd1;
    if (!we) begin
      val = (word >> (8 * off)) & mask;
      if (f3 < 3'd4 && bytes < 4 && val[8*bytes-1]) val = val | ~mask;
      data = val[31:0];
      lat  = 2;
    end else if (bytes == 4) begin
      wword = wdata;
      lat   = 2;
      wcyc  = 1;
    end else begin
      val   = (word & ~(mask << (8 * off))) | ((64'(wdata) & mask) << (8 * off));
      wword = val[31:0];
      lat   = 3;
      wcyc  = 2;
    end
  endfunction

  // Issues one request with rsp_ready held high; returns at the negedge after the handshake.
  task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output bit err, output logic [31:0] data,
                         output int lat, output int nwr, output int wcyc,
                         output logic [31:0] wdat);
    err  = 1'b0;
    data = 32'h0;
    lat  = -1;
    nwr  = 0;
    wcyc = -1;
    wdat = 32'h0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.mem_write_enable) begin
        nwr++;
        wcyc = c;
        wdat = bus.mem_write_data;
      end
      if (bus.rsp_valid) begin
        lat  = c;
        err  = bus.rsp_err;
        data = bus.rsp_data;
        break;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_req(input string tag, input bit we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit e_err,
                           input logic [31:0] e_data, input int e_lat, input int e_wcyc,
                           input logic [31:0] e_wword);
    bit          g_err;
    logic [31:0] g_data, g_wdat;
    int          g_lat, g_nwr, g_wcyc;
    run_req(we, f3, addr, wdata, g_err, g_data, g_lat, g_nwr, g_wcyc, g_wdat);
    chk({tag, " rsp_err"}, 32'(g_err), 32'(e_err));
    chk({tag, " rsp_data"}, g_data, e_data);
    chk({tag, " rsp latency"}, 32'(g_lat), 32'(e_lat));
    chk({tag, " write pulses"}, 32'(g_nwr), (e_wcyc >= 0) ? 32'd1 : 32'd0);
    if (e_wcyc >= 0) begin
      chk({tag, " write cycle"}, 32'(g_wcyc), 32'(e_wcyc));
      chk({tag, " write data"}, g_wdat, e_wword);
      ref_mem[addr / 4] = e_wword;
    end
    chk({tag, " req_ready after rsp"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          m_err;
    logic [31:0] m_data, m_wword, addr, exp_word;
    logic [2:0]  f3;
    bit          we;
    int          m_lat, m_wcyc, w0;

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b1;
    for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = $urandom;
    ref_mem[1]  = 32'h8765_4321;
    ref_mem[2]  = 32'h1122_3344;
    ref_mem[63] = 32'h8000_0000;
    init_mem = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    init_mem = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_data", bus.rsp_data, 32'h0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset mem_address", bus.mem_address, 32'h0);
    chk("reset mem_write_data", bus.mem_write_data, 32'h0);
    chk("reset mem_write_enable", 32'(bus.mem_write_enable), 32'd0);

    // we f3 addr wdata | err data lat wcyc wword
    vecs.push_back('{1'b0, 3'b000, 32'h7,   32'h0,         1'b0, 32'hFFFF_FF87, 2, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b100, 32'h7,   32'h0,         1'b0, 32'h0000_0087, 2, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b001, 32'h4,   32'h0,         1'b0, 32'h0000_4321, 2, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b101, 32'h6,   32'h0,         1'b0, 32'h0000_8765, 2, -1, 32'h0});
    vecs.push_back('{1'b1, 3'b000, 32'h9,   32'hAABB_CCDD, 1'b0, 32'h0, 3, 2, 32'h1122_DD44});
    vecs.push_back('{1'b0, 3'b010, 32'h8,   32'h0,         1'b0, 32'h1122_DD44, 2, -1, 32'h0});
    vecs.push_back('{1'b1, 3'b010, 32'hC,   32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 3'b010, 32'hC,   32'h0,         1'b0, 32'hDEAD_BEEF, 2, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b010, 32'h2,   32'h0,         1'b1, 32'h0, 1, -1, 32'h0});
    vecs.push_back('{1'b1, 3'b001, 32'h1,   32'h1234_5678, 1'b1, 32'h0, 1, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b000, 32'h100, 32'h0,         1'b1, 32'h0, 1, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b011, 32'h0,   32'h0,         1'b1, 32'h0, 1, -1, 32'h0});
    vecs.push_back('{1'b0, 3'b000, 32'hFF,  32'h0,         1'b0, 32'hFFFF_FF80, 2, -1, 32'h0});
    vecs.push_back('{1'b1, 3'b011, 32'h0,   32'h0,         1'b1, 32'h0, 1, -1, 32'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      check_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                vecs[i].err, vecs[i].data, vecs[i].lat, vecs[i].wcyc, vecs[i].wword);
    end

    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        addr = $urandom;
      end else begin
        addr = 32'($urandom_range(0, 4 * WORDS - 1));
        if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << int'(f3 & 3'd3)) - 32'd1);
      end
      model(we, f3, addr, $urandom, m_err, m_data, m_lat, m_wcyc, m_wword);
      // The model consumed one $urandom for wdata; recompute with a fixed value instead.
      addr = addr;
      m_wword = $urandom;
      model(we, f3, addr, m_wword, m_err, m_data, m_lat, m_wcyc, exp_word);
      check_req($sformatf("rnd%0d", i), we, f3, addr, m_wword, m_err, m_data, m_lat, m_wcyc,
                exp_word);
    end

    // Back-pressure: response must hold and a new request must be ignored.
    exp_word = ref_mem[1];
    w0 = wr_total;
    @(negedge clk);
    bus.rsp_ready  = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h4;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hold first rsp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h14;
    bus.req_wdata  = 32'h5555_AAAA;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold rsp_data", bus.rsp_data, exp_word);
      chk("hold req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("release req_ready", 32'(bus.req_ready), 32'd1);
    chk("release rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("hold no write", 32'(wr_total), 32'(w0));

    // Reset while an SH sits in its read cycle: no write, no response.
    w0 = wr_total;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr   = 32'h12;
    bus.req_wdata  = 32'h0000_BEEF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst rsp_valid later", 32'(bus.rsp_valid), 32'd0);
    chk("rst no write", 32'(wr_total), 32'(w0));
    chk("rst word unchanged", mem[4], ref_mem[4]);

    for (int i = 0; i < int'(WORDS); i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
